// File: rtl/fpu_pkg.sv
// Shared FPU definitions: radix-4 Booth digit codes and multiplier controller states.
package fpu_pkg;

    typedef enum logic [2:0] {
        BOOTH_0  = 3'b000,
        BOOTH_P1 = 3'b001,
        BOOTH_P2 = 3'b010,
        BOOTH_N1 = 3'b101,
        BOOTH_N2 = 3'b110
    } booth_digit_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/booth_enc_r4.sv
// Radix-4 Booth recoder: maps a multiplier bit triplet {b[2i+1], b[2i], b[2i-1]} to a digit.
module booth_enc_r4
    import fpu_pkg::*;
(
    input  logic [2:0]   trip,
    output booth_digit_t digit
);

    always_comb begin
        digit = BOOTH_0;
        unique case (trip)
            3'b000, 3'b111: digit = BOOTH_0;
            3'b001, 3'b010: digit = BOOTH_P1;
            3'b011:         digit = BOOTH_P2;
            3'b100:         digit = BOOTH_N2;
            3'b101, 3'b110: digit = BOOTH_N1;
            default:        digit = BOOTH_0;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative unsigned radix-4 Booth multiplier: one Booth digit per cycle into a shift-add accumulator.
module booth_mul_seq
    import fpu_pkg::*;
#(
    parameter int DWIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DWIDTH-1:0]     in_a,
    input  logic [DWIDTH-1:0]     in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DWIDTH-1:0]   out_p,
    output logic                  busy
);

    localparam int NITER = (DWIDTH + 2) / 2;
    localparam int BW    = 2 * NITER;
    localparam int AW    = 2 * DWIDTH + 2;
    localparam int PW    = DWIDTH + 2;
    localparam int CW    = $clog2(NITER + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NITER - 1);

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // producer holds data stable while valid is high and ready is low.

    mul_state_t        state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [DWIDTH-1:0] a_q;
    logic [BW:0]       b_q;      // {B_ext, implicit b[-1]=0}
    logic [AW-1:0]     acc;

    logic [CW:0]       shamt;
    logic [2:0]        trip;
    booth_digit_t      digit;
    logic [PW-1:0]     a_x1, a_x2, pp;
    logic [AW-1:0]     addend;

    assign shamt = {cnt, 1'b0};
    assign trip  = b_q[shamt +: 3];

    booth_enc_r4 u_enc (
        .trip  (trip),
        .digit (digit)
    );

    assign a_x1 = {2'b00, a_q};
    assign a_x2 = {1'b0, a_q, 1'b0};

    always_comb begin
        pp = '0;
        unique case (digit)
            BOOTH_P1: pp = a_x1;
            BOOTH_P2: pp = a_x2;
            BOOTH_N1: pp = -a_x1;
            BOOTH_N2: pp = -a_x2;
            default:  pp = '0;
        endcase
    end

    assign addend = {{(AW-PW){pp[PW-1]}}, pp} << shamt;

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: if (in_valid) state_nxt = ST_RUN;
                ST_RUN:  if (cnt == LAST_CNT) state_nxt = ST_DONE;
                ST_DONE: if (out_ready) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
        end else if (abort) begin
            cnt <= '0;
            acc <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q <= in_a;
                        b_q <= {{(BW-DWIDTH){1'b0}}, in_b, 1'b0};
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                ST_RUN: begin
                    acc <= acc + addend;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    // Upper accumulator bits only hold sign extension of partial sums; they are zero once DONE.
    assign out_p     = (out_valid && (acc[AW-1:2*DWIDTH] == '0)) ? acc[2*DWIDTH-1:0] : '0;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and short random stimulus for booth_mul_seq, checked by a queue-based scoreboard.
module tb_booth_mul_seq;

    localparam int DW    = 11;
    localparam int PW    = 2 * DW;
    localparam int NITER = (DW + 2) / 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_p;
    logic          busy;

    int            total = 0;
    int            bad = 0;
    logic [PW-1:0] exp_q[$];
    bit            stall_en = 1'b0;

    booth_mul_seq #(.DWIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (stall_en) begin
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    // Drive one operand pair and hold it until accepted; optionally push the expected product.
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [PW-1:0] exp_p, input bit push);
        int n;
        n = 0;
        @(posedge clk); #1;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1");
        end else if (push) begin
            exp_q.push_back(exp_p);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || !in_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || !in_ready) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got pending=%0d want 0", exp_q.size());
        end
    endtask

    // ---------------- random out_ready stalls ----------------
    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [PW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_product: got 0x%0h want none", out_p);
                end else begin
                    e = exp_q.pop_front();
                    check("product", out_p, e);
                end
            end
        end
    end

    // ---------------- directed vectors ----------------
    logic [DW-1:0] va [4] = '{11'h400, 11'h555, 11'h000, 11'h001};
    logic [DW-1:0] vb [4] = '{11'h400, 11'h2AA, 11'h7FF, 11'h001};
    logic [PW-1:0] vp [4] = '{22'h100000, 22'h0E3472, 22'h000000, 22'h000001};

    initial begin
        int n;
        bit seen;
        logic [DW-1:0] ra, rb;

        // reset state
        #2;
        check("rst_in_ready", PW'(in_ready), 1);
        check("rst_out_valid", PW'(out_valid), 0);
        check("rst_busy", PW'(busy), 0);
        check("rst_out_p", out_p, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // max operands and latency: counting the accept cycle, out_valid shows 7 cycles later
        send(11'h7FF, 11'h7FF, 22'h3FF001, 1'b1);
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        check("latency", PW'(n), PW'(NITER + 1));
        wait_drain();

        // directed table, back to back
        for (int i = 0; i < 4; i++) send(va[i], vb[i], vp[i], 1'b1);
        wait_drain();

        // backpressure: product held, no new accept
        out_ready = 1'b0;
        send(11'h3E8, 11'h064, 22'h0186A0, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", PW'(out_valid), 1);
            check("bp_out_p", out_p, 22'h0186A0);
            check("bp_in_ready", PW'(in_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", PW'(out_valid), 0);
        check("bp_release_ready", PW'(in_ready), 1);
        wait_drain();

        // in_valid with fresh operands during RUN must be ignored
        send(11'h0AB, 11'h0CD, 22'h0088EF, 1'b1);
        in_a = 11'h7FF;
        in_b = 11'h7FF;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("run_in_ready", PW'(in_ready), 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain();

        // abort while cnt==3: op discarded
        send(11'h7FF, 11'h7FF, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", PW'(busy), 0);
        check("abort_in_ready", PW'(in_ready), 1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_valid", PW'(seen), 0);
        send(11'h123, 11'h456, 22'h04EDC2, 1'b1);
        wait_drain();

        // asynchronous reset mid-RUN
        send(11'h7FF, 11'h001, '0, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", PW'(in_ready), 1);
        check("arst_out_valid", PW'(out_valid), 0);
        check("arst_busy", PW'(busy), 0);
        check("arst_out_p", out_p, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        check("arst_no_pulse", PW'(seen), 0);
        send(11'd2, 11'd3, 22'd6, 1'b1);
        wait_drain();

        // short random run with consumer stalls, a*b reference model
        stall_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = DW'($urandom_range(0, 2047));
            rb = DW'($urandom_range(0, 2047));
            send(ra, rb, PW'(ra) * PW'(rb), 1'b1);
        end
        wait_drain();
        stall_en = 1'b0;
        out_ready = 1'b1;

        check("queue_empty", PW'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
